pipe_hazard_ctrl: RTL and testbench

//   Pipeline hazard and stall scheduler for the five-stage MIPS32 core. Detects load-use

---
 rtl/pipe_hazard_ctrl_if.sv | 45 ++++
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the MIPS32 pipeline stages and the scheduler.
// Carries ID/EXE operand info in and the hold/flush/divider controls out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_re1;
  logic [4:0]       id_ra1;
  logic             id_re2;
  logic [4:0]       id_ra2;
  logic [4:0]       exe_wa;
  logic             exe_wreg;
  logic             exe_mreg;
  logic             exe_div;
  logic             exc_req;
  logic             pc_hold;
  logic             ifid_hold;
  logic             idexe_hold;
  logic             ifid_flush;
  logic             idexe_flush;
  logic             exemem_flush;
  logic             div_start;
  logic             div_done;
  logic             div_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_re1, id_ra1, id_re2, id_ra2,
    output exe_wa, exe_wreg, exe_mreg, exe_div,
    output exc_req,
    input  pc_hold, ifid_hold, idexe_hold,
    input  ifid_flush, idexe_flush, exemem_flush,
    input  div_start, div_done, div_busy,
    input  stall_cnt
  );

  modport slave (
    input  id_re1, id_ra1, id_re2, id_ra2,
    input  exe_wa, exe_wreg, exe_mreg, exe_div,
    input  exc_req,
    output pc_hold, ifid_hold, idexe_hold,
    output ifid_flush, idexe_flush, exemem_flush,
    output div_start, div_done, div_busy,
    output stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / divider stall scheduler with exception flush for the 5-stage core.
// Controls are combinational from state, count and inputs; stall counter saturates.
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(DIV_CYCLES - 1);

  typedef enum logic {
    IDLE,
    DIV_BUSY
  } state_t;

  state_t           r_state;
  state_t           w_nstate;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_ncnt;
  logic [CNT_W-1:0] r_stall;

  logic w_lu;
  logic w_pc_hold;
  logic w_ifid_hold;
  logic w_idexe_hold;
  logic w_ifid_flush;
  logic w_idexe_flush;
  logic w_exemem_flush;
  logic w_div_start;
  logic w_div_done;
  logic w_div_busy;

  assign w_lu = bus.exe_mreg & bus.exe_wreg &
                (bus.exe_wa != 5'd0) &
                ((bus.id_re1 & (bus.id_ra1 == bus.exe_wa)) |
                 (bus.id_re2 & (bus.id_ra2 == bus.exe_wa)));

  always_comb begin
    w_nstate       = r_state;
    w_ncnt         = r_cnt;
    w_pc_hold      = 1'b0;
    w_ifid_hold    = 1'b0;
    w_idexe_hold   = 1'b0;
    w_ifid_flush   = 1'b0;
    w_idexe_flush  = 1'b0;
    w_exemem_flush = 1'b0;
    w_div_start    = 1'b0;
    w_div_done     = 1'b0;
    w_div_busy     = 1'b0;
    if (!rst) begin
      w_div_busy = (r_state == DIV_BUSY);
      if (bus.exc_req) begin
        // Exception overrides everything and kills any divide.
        w_ifid_flush   = 1'b1;
        w_idexe_flush  = 1'b1;
        w_exemem_flush = 1'b1;
        w_nstate       = IDLE;
        w_ncnt         = '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.exe_div) begin
              w_div_start    = 1'b1;
              w_pc_hold      = 1'b1;
              w_ifid_hold    = 1'b1;
              w_idexe_hold   = 1'b1;
              w_exemem_flush = 1'b1;
              w_nstate       = DIV_BUSY;
              w_ncnt         = LOAD;
            end else if (w_lu) begin
              w_pc_hold     = 1'b1;
              w_ifid_hold   = 1'b1;
              w_idexe_flush = 1'b1;
            end
          end
          DIV_BUSY: begin
            if (r_cnt != '0) begin
              w_pc_hold      = 1'b1;
              w_ifid_hold    = 1'b1;
              w_idexe_hold   = 1'b1;
              w_exemem_flush = 1'b1;
              w_ncnt         = r_cnt - 1'b1;
            end else begin
              w_div_done = 1'b1;
              w_nstate   = IDLE;
            end
          end
          default: begin
            w_nstate = IDLE;
            w_ncnt   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      if (w_pc_hold && (r_stall != '1)) begin
        r_stall <= r_stall + CNT_W'(1);
      end
    end
  end

  assign bus.pc_hold      = w_pc_hold;
  assign bus.ifid_hold    = w_ifid_hold;
  assign bus.idexe_hold   = w_idexe_hold;
  assign bus.ifid_flush   = w_ifid_flush;
  assign bus.idexe_flush  = w_idexe_flush;
  assign bus.exemem_flush = w_exemem_flush;
  assign bus.div_start    = w_div_start;
  assign bus.div_done     = w_div_done;
  assign bus.div_busy     = w_div_busy;
  assign bus.stall_cnt    = r_stall;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, directed divider/reset sequences,
// and random traffic checked against a timestamp-based reference model.
module tb_pipe_hazard_ctrl;
  localparam int DIVC = 32;
  localparam int CW   = 8;
  localparam int SMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(
    .DIV_CYCLES(DIVC),
    .CNT_W     (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic       rst;
    logic       re1;
    logic [4:0] ra1;
    logic       re2;
    logic [4:0] ra2;
    logic [4:0] wa;
    logic       wreg;
    logic       mreg;
    logic       div;
    logic       exc;
  } in_t;

  typedef struct {
    in_t        i;
    logic [8:0] exp;
  } vec_t;

  int pass_n = 0;
  int tot_n  = 0;

  bit m_busy;
  int m_t0;
  int m_cyc;
  int m_stall;

  logic [8:0]  s_ctrl;
  logic [31:0] s_cnt;

  // ctrl bits: pc,ifid,idexe hold | ifid,idexe,exemem flush | start,done,busy
  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_n++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else
      pass_n++;
  endtask

  function automatic in_t mk(input logic r, input logic re1,
                             input logic [4:0] ra1, input logic re2,
                             input logic [4:0] ra2, input logic [4:0] wa,
                             input logic wreg, input logic mreg,
                             input logic div, input logic exc);
    in_t v;
    v.rst = r; v.re1 = re1; v.ra1 = ra1; v.re2 = re2; v.ra2 = ra2;
    v.wa = wa; v.wreg = wreg; v.mreg = mreg; v.div = div; v.exc = exc;
    return v;
  endfunction

  function automatic logic [8:0] model_ctrl(input in_t v);
    logic [8:0] r;
    int k;
    bit lu;
    r = '0;
    k = m_cyc - m_t0;
    lu = v.mreg && v.wreg && (v.wa != 0) &&
         ((v.re1 && v.ra1 == v.wa) || (v.re2 && v.ra2 == v.wa));
    if (!v.rst) begin
      r[0] = m_busy;
      if (v.exc) begin
        r[5:3] = 3'b111;
      end else if (m_busy) begin
        if (k < DIVC) begin
          r[8:6] = 3'b111;
          r[3]   = 1'b1;
        end else begin
          r[1] = 1'b1;
        end
      end else if (v.div) begin
        r[8:6] = 3'b111;
        r[3]   = 1'b1;
        r[2]   = 1'b1;
      end else if (lu) begin
        r[8] = 1'b1;
        r[7] = 1'b1;
        r[4] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic drive(input in_t v);
    rst          = v.rst;
    bus.id_re1   = v.re1;
    bus.id_ra1   = v.ra1;
    bus.id_re2   = v.re2;
    bus.id_ra2   = v.ra2;
    bus.exe_wa   = v.wa;
    bus.exe_wreg = v.wreg;
    bus.exe_mreg = v.mreg;
    bus.exe_div  = v.div;
    bus.exc_req  = v.exc;
  endtask

  task automatic cycle(input in_t v);
    logic [8:0] e;
    int k;
    drive(v);
    @(negedge clk);
    e = model_ctrl(v);
    s_ctrl = {bus.pc_hold, bus.ifid_hold, bus.idexe_hold,
              bus.ifid_flush, bus.idexe_flush, bus.exemem_flush,
              bus.div_start, bus.div_done, bus.div_busy};
    s_cnt = 32'(bus.stall_cnt);
    chk("ctrl", 32'(s_ctrl), 32'(e));
    chk("stall_cnt", s_cnt, 32'(m_stall));
    k = m_cyc - m_t0;
    if (v.rst) begin
      m_busy  = 0;
      m_stall = 0;
    end else begin
      if (e[8] && m_stall < SMAX) m_stall++;
      if (v.exc) m_busy = 0;
      else if (m_busy && k >= DIVC) m_busy = 0;
      else if (!m_busy && v.div) begin
        m_busy = 1;
        m_t0   = m_cyc;
      end
    end
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input in_t v, input string nm,
                           output int lat);
    lat = -1;
    for (int i = 1; i <= DIVC + 8; i++) begin
      cycle(v);
      if (s_ctrl[1]) begin
        lat = i;
        break;
      end
    end
    chk(nm, 32'(lat), 32'(DIVC));
  endtask

  vec_t tbl[9];
  in_t  idle, vdiv, vlu, vdlu, vrst;
  int   lat;
  logic [31:0] sc0;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vdiv = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vlu  = mk(0, 1, 8, 0, 0, 8, 1, 1, 0, 0);
    vdlu = mk(0, 1, 8, 0, 0, 8, 1, 1, 1, 0);
    vrst = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0] = '{mk(0, 1, 8, 0, 0, 8, 1, 1, 0, 0), 9'b110_010_000};
    tbl[1] = '{mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0), 9'b000_000_000};
    tbl[2] = '{mk(0, 0, 0, 0, 9, 9, 1, 1, 0, 0), 9'b000_000_000};
    tbl[3] = '{mk(0, 0, 0, 1, 9, 9, 1, 1, 0, 0), 9'b110_010_000};
    tbl[4] = '{mk(0, 1, 8, 0, 0, 8, 0, 1, 0, 0), 9'b000_000_000};
    tbl[5] = '{mk(0, 1, 8, 0, 0, 8, 1, 0, 0, 0), 9'b000_000_000};
    tbl[6] = '{mk(0, 1, 8, 0, 0, 8, 1, 1, 0, 1), 9'b000_111_000};
    tbl[7] = '{mk(0, 1, 3, 1, 4, 5, 1, 1, 0, 0), 9'b000_000_000};
    tbl[8] = '{mk(1, 1, 8, 0, 0, 8, 1, 1, 0, 0), 9'b000_000_000};

    drive(vrst);
    @(posedge clk);
    #1;
    m_busy = 0; m_t0 = 0; m_cyc = 0; m_stall = 0;

    cycle(vrst);
    chk("reset_ctrl", 32'(s_ctrl), 32'd0);
    chk("reset_cnt", s_cnt, 32'd0);

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].i);
      chk($sformatf("tbl%0d", i), 32'(s_ctrl), 32'(tbl[i].exp));
    end

    // single load-use stall counts once
    cycle(vrst);
    cycle(vlu);
    cycle(idle);
    chk("lu_cnt", s_cnt, 32'd1);

    // full-length divide
    cycle(vdiv);
    chk("t3_start", 32'(s_ctrl[2]), 32'd1);
    sc0 = s_cnt;
    wait_done(vdiv, "t3_latency", lat);
    chk("t3_stall_delta", s_cnt - sc0, 32'(DIVC));
    cycle(idle);
    chk("t3_idle", 32'(s_ctrl), 32'd0);

    // exception aborts at t0+10, then restart
    cycle(vdiv);
    for (int i = 1; i < 10; i++) cycle(vdiv);
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    chk("t4_flush", 32'(s_ctrl[5:3]), 32'd7);
    chk("t4_nodone", 32'(s_ctrl[1]), 32'd0);
    cycle(idle);
    chk("t4_busy", 32'(s_ctrl[0]), 32'd0);
    chk("t4_nodone2", 32'(s_ctrl[1]), 32'd0);
    cycle(vdiv);
    chk("t4_restart", 32'(s_ctrl[2]), 32'd1);
    wait_done(vdiv, "t4_latency", lat);

    // divider beats load-use
    cycle(vdlu);
    chk("t5_start", 32'(s_ctrl[2]), 32'd1);
    chk("t5_noflush", 32'(s_ctrl[4]), 32'd0);
    wait_done(vdlu, "t5_latency", lat);
    cycle(vlu);
    chk("t5_lu_after", 32'(s_ctrl), 32'h190);

    // reset mid-divide at cnt=5
    cycle(vdiv);
    for (int i = 1; i < 27; i++) cycle(vdiv);
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    chk("t6_rst_out", 32'(s_ctrl), 32'd0);
    cycle(idle);
    chk("t6_after", 32'(s_ctrl), 32'd0);
    chk("t6_cnt", s_cnt, 32'd0);

    // saturation
    for (int i = 0; i < SMAX + 10; i++) cycle(vlu);
    cycle(vlu);
    chk("sat", s_cnt, 32'(SMAX));
    cycle(vlu);
    chk("sat_hold", s_cnt, 32'(SMAX));

    // random traffic
    cycle(vrst);
    for (int n = 0; n < 3000; n++) begin
      in_t r;
      r = mk(($urandom % 80) == 0, 1'($urandom), 5'($urandom % 4),
             1'($urandom), 5'($urandom % 4), 5'($urandom % 4),
             1'($urandom), 1'($urandom), ($urandom % 10) == 0,
             ($urandom % 40) == 0);
      cycle(r);
    end

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
